// File: rtl/fwft_upsizer.sv
// fwft_upsizer: packs RATIO narrow words popped from an upstream FWFT FIFO
// into one wide output word with a per-lane keep mask.
// Optional partial-word flush: define FWFT_UPSIZER_FLUSH_EN to add i_flush.
module fwft_upsizer #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  input  logic                      i_empty,
  input  logic [IN_WIDTH-1:0]       i_rd_data,
  output logic                      o_rd_en,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [IN_WIDTH*RATIO-1:0] o_data,
  output logic [RATIO-1:0]          o_keep
`ifdef FWFT_UPSIZER_FLUSH_EN
  ,
  input  logic                      i_flush
`endif
);

  localparam int unsigned     LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned     OW    = IN_WIDTH * RATIO;
  localparam logic [LW-1:0]   LAST  = LW'(RATIO - 1);

  logic [LW-1:0]       lane_idx;
  logic [IN_WIDTH-1:0] lane_q [RATIO];

  logic                valid_q;
  logic [OW-1:0]       data_q;
  logic [RATIO-1:0]    keep_q;

  logic                flush_pending;
  logic                flush_emit;
  logic [OW-1:0]       flush_word;
  logic [RATIO-1:0]    flush_keep;

  logic                stall;
  logic                rd_en;
  logic                complete;
  logic                out_free;
  logic [OW-1:0]       full_word;

  // The last lane can only be popped when the output register can take the word.
  assign stall    = (lane_idx == LAST) && valid_q && !i_ready;
  assign rd_en    = !i_empty && !stall && !flush_pending && !i_clr && rst_n;
  assign complete = rd_en && (lane_idx == LAST);
  assign out_free = !valid_q || i_ready;

  assign o_rd_en  = rd_en;
  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_keep   = keep_q;

  // Full word: stored lanes below the last, plus the word being popped now.
  always_comb begin
    full_word = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      full_word[k*IN_WIDTH +: IN_WIDTH] = lane_q[k];
    end
    full_word[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = i_rd_data;
  end

`ifdef FWFT_UPSIZER_FLUSH_EN
  logic flush_drop;

  assign flush_emit = flush_pending && (lane_idx != '0) && out_free;
  assign flush_drop = flush_pending && (lane_idx == '0);

  // Partial word: filled lanes below lane_idx, unfilled lanes forced to zero.
  always_comb begin
    flush_word = '0;
    flush_keep = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k < 32'(lane_idx)) begin
        flush_word[k*IN_WIDTH +: IN_WIDTH] = lane_q[k];
        flush_keep[k]                      = 1'b1;
      end
    end
  end

  // Flush request latch; a pop in the request cycle lands before it is served.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      flush_pending <= 1'b0;
    end else if (i_flush) begin
      flush_pending <= 1'b1;
    end else if (flush_emit || flush_drop) begin
      flush_pending <= 1'b0;
    end
  end
`else
  assign flush_pending = 1'b0;
  assign flush_emit    = 1'b0;
  assign flush_word    = '0;
  assign flush_keep    = '0;
`endif

  // Lane write index; wraps after the group completes or a partial word is flushed.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      lane_idx <= '0;
    end else if (rd_en) begin
      lane_idx <= (lane_idx == LAST) ? '0 : lane_idx + LW'(1);
    end else if (flush_emit) begin
      lane_idx <= '0;
    end
  end

  // Lane storage; contents only matter below lane_idx, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      lane_q[lane_idx] <= i_rd_data;
    end
  end

  // Output register: load on completion or flush, otherwise drain on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (complete) begin
      valid_q <= 1'b1;
      data_q  <= full_word;
      keep_q  <= '1;
    end else if (flush_emit) begin
      valid_q <= 1'b1;
      data_q  <= flush_word;
      keep_q  <= flush_keep;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule
